ami_spi_reader: RTL and testbench

- SPI read engine for the AMI monitoring ADC path. Counterpart to the write-only AFE SPI driver: it drives SCLK/SDI/CSB and captures AMI_SPI_SDO readback.
- Accepts a command word from the host, clocks it out MSB first, then shifts in a DATA_WIDTH response word on SDO and presents it with a one-cycle valid strobe.
- Two instances sit between the system register block and the AMI_SPI_* pins.

---
 rtl/ami_spi_pkg.sv | 30 +++
 rtl/ami_spi_reader_if.sv | 34 +++
 rtl/ami_spi_tick.sv | 39 +++
 rtl/ami_spi_reader.sv | 150 +++++++++++++++
 tb/tb_ami_spi_reader.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ami_spi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ami_spi_pkg : shared types, default widths and SCLK half-period helper
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package ami_spi_pkg;

  localparam int DEF_CLK_RATE   = 99999001;
  localparam int DEF_SPI_RATE   = 10000000;
  localparam int DEF_CMD_WIDTH  = 8;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Rounds up so the generated SCLK never exceeds spi_rate.
  function automatic int calc_half(longint clk_rate, longint spi_rate);
    longint div;
    longint h;
    div = 2 * spi_rate;
    h   = (clk_rate + div - 1) / div;
    return (h < 1) ? 1 : int'(h);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ami_spi_reader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ami_spi_reader_if : host-side command/response handshake of the SPI reader
// Revision          : 1.0 - initial release
// ---------------------------------------------------------------------------
interface ami_spi_reader_if import ami_spi_pkg::*; #(
  parameter int CMD_WIDTH  = DEF_CMD_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  start;
  logic [CMD_WIDTH-1:0]  cmd;
  logic                  busy;
  logic                  dataValid;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output start,
    output cmd,
    input  busy,
    input  dataValid,
    input  data
  );

  modport slave (
    input  start,
    input  cmd,
    output busy,
    output dataValid,
    output data
  );

endinterface
`default_nettype wire

// File: rtl/ami_spi_tick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ami_spi_tick : strobes once every HALF cycles; restarts the count on clear
// Revision     : 1.0 - initial release
// ---------------------------------------------------------------------------
module ami_spi_tick #(
  parameter int HALF = 5
) (
  input  logic sysClk,
  input  logic sysReset,
  input  logic clear,
  output logic tick
);

  localparam int             CNT_W    = $clog2(HALF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/ami_spi_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ami_spi_reader : shifts a command out on SDI, then captures a response on SDO
// Revision       : 1.0 - initial release
// ---------------------------------------------------------------------------
module ami_spi_reader import ami_spi_pkg::*; #(
  parameter int CLK_RATE   = DEF_CLK_RATE,
  parameter int SPI_RATE   = DEF_SPI_RATE,
  parameter int CMD_WIDTH  = DEF_CMD_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic              sysClk,
  input  logic              sysReset,
  ami_spi_reader_if.slave   host,
  output logic              SPI_CLK,
  output logic              SPI_SDI,
  input  logic              SPI_SDO,
  output logic              SPI_CSB
);

  localparam int               HALF     = calc_half(CLK_RATE, SPI_RATE);
  localparam int               NBITS    = CMD_WIDTH + DATA_WIDTH;
  localparam int               BIT_W    = $clog2(NBITS + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

  state_e                state_q,  state_d;
  logic                  phase_hi_q, phase_hi_d;
  logic [BIT_W-1:0]      bit_q,    bit_d;
  logic [CMD_WIDTH-1:0]  tx_q,     tx_d;
  logic [DATA_WIDTH-1:0] rx_q,     rx_d;
  logic [DATA_WIDTH-1:0] data_q,   data_d;
  logic                  valid_q,  valid_d;
  logic                  busy_q,   busy_d;
  logic                  sclk_q,   sclk_d;
  logic                  sdi_q,    sdi_d;
  logic                  csb_q,    csb_d;
  logic                  accept;
  logic                  tick;

  assign accept = (state_q == ST_IDLE) && host.start;

  ami_spi_tick #(.HALF(HALF)) u_tick (
    .sysClk   (sysClk),
    .sysReset (sysReset),
    .clear    (accept),
    .tick     (tick)
  );

  always_comb begin
    state_d    = state_q;
    phase_hi_d = phase_hi_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    sclk_d     = sclk_q;
    sdi_d      = sdi_q;
    csb_d      = csb_q;
    case (state_q)
      ST_IDLE: begin
        if (host.start) begin
          state_d = ST_SETUP;
          tx_d    = host.cmd;
          rx_d    = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
          csb_d   = 1'b0;
          sclk_d  = 1'b0;
          sdi_d   = host.cmd[CMD_WIDTH-1];
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d    = ST_SHIFT;
          phase_hi_d = 1'b1;
          sclk_d     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (phase_hi_q) begin
            // Zeros fill tx behind the command, so SDI idles low for the data bits.
            rx_d       = {rx_q[DATA_WIDTH-2:0], SPI_SDO};
            tx_d       = {tx_q[CMD_WIDTH-2:0], 1'b0};
            sdi_d      = tx_q[CMD_WIDTH-2];
            phase_hi_d = 1'b0;
            sclk_d     = 1'b0;
          end else if (bit_q == BIT_LAST) begin
            state_d = ST_GAP;
            csb_d   = 1'b1;
            data_d  = rx_q;
            valid_d = 1'b1;
          end else begin
            bit_d      = bit_q + BIT_W'(1);
            phase_hi_d = 1'b1;
            sclk_d     = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state_q    <= ST_IDLE;
      phase_hi_q <= 1'b0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      sdi_q      <= 1'b0;
      csb_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_hi_q <= phase_hi_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      sdi_q      <= sdi_d;
      csb_q      <= csb_d;
    end
  end

  assign host.busy      = busy_q;
  assign host.dataValid = valid_q;
  assign host.data      = data_q;
  assign SPI_CLK        = sclk_q;
  assign SPI_SDI        = sdi_q;
  assign SPI_CSB        = csb_q;

endmodule
`default_nettype wire

// File: tb/tb_ami_spi_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ami_spi_reader : timing-model checker for two reader instances (HALF=5, HALF=1)
// Revision          : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_ami_spi_reader;

  localparam int CW = 8;
  localparam int DW = 16;
  localparam int NB = CW + DW;
  localparam int H0 = (99999001 + 2 * 10000000 - 1) / (2 * 10000000);
  localparam int H1 = (100000000 + 2 * 50000000 - 1) / (2 * 50000000);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    rst_s   = 2'b11;
  logic [1:0]    start_s = 2'b00;
  logic [CW-1:0] cmd_s  [2];
  logic [DW-1:0] resp_s [2];
  logic          en = 1'b0;

  wire  [1:0]    sclk_a, sdi_a, csb_a, sdo_a, busy_a, valid_a;
  wire  [DW-1:0] data0, data1;

  int n_err    = 0;
  int n_checks = 0;

  ami_spi_reader_if #(.CMD_WIDTH(CW), .DATA_WIDTH(DW)) if0 ();
  ami_spi_reader_if #(.CMD_WIDTH(CW), .DATA_WIDTH(DW)) if1 ();

  assign if0.start = start_s[0];
  assign if0.cmd   = cmd_s[0];
  assign if1.start = start_s[1];
  assign if1.cmd   = cmd_s[1];
  assign busy_a[0]  = if0.busy;
  assign busy_a[1]  = if1.busy;
  assign valid_a[0] = if0.dataValid;
  assign valid_a[1] = if1.dataValid;
  assign data0      = if0.data;
  assign data1      = if1.data;

  ami_spi_reader #(.CLK_RATE(99999001), .SPI_RATE(10000000), .CMD_WIDTH(CW), .DATA_WIDTH(DW)) dut0 (
    .sysClk(clk), .sysReset(rst_s[0]), .host(if0),
    .SPI_CLK(sclk_a[0]), .SPI_SDI(sdi_a[0]), .SPI_SDO(sdo_a[0]), .SPI_CSB(csb_a[0])
  );

  ami_spi_reader #(.CLK_RATE(100000000), .SPI_RATE(50000000), .CMD_WIDTH(CW), .DATA_WIDTH(DW)) dut1 (
    .sysClk(clk), .sysReset(rst_s[1]), .host(if1),
    .SPI_CLK(sclk_a[1]), .SPI_SDI(sdi_a[1]), .SPI_SDO(sdo_a[1]), .SPI_CSB(csb_a[1])
  );

  function automatic int half_of(int id);
    return (id == 0) ? H0 : H1;
  endfunction

  function automatic logic [DW-1:0] data_of(int id);
    return (id == 0) ? data0 : data1;
  endfunction

  // SPI slave: ones while the command is clocked in, then the response MSB first.
  int fc [2] = '{0, 0};
  always @(negedge csb_a[0]) fc[0] = 0;
  always @(negedge sclk_a[0]) fc[0] = fc[0] + 1;
  always @(negedge csb_a[1]) fc[1] = 0;
  always @(negedge sclk_a[1]) fc[1] = fc[1] + 1;

  function automatic logic slave_bit(int idx, logic [DW-1:0] r);
    if (idx < CW || idx >= NB) return 1'b1;
    return r[NB-1-idx];
  endfunction

  assign sdo_a[0] = slave_bit(fc[0], resp_s[0]);
  assign sdo_a[1] = slave_bit(fc[1], resp_s[1]);

  task automatic chk(input string nm, input int id, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, id, $time, act_v, exp_v);
    end
  endtask

  // Reference model: each transaction is a timeline indexed by cycles since acceptance.
  bit            act   [2] = '{1'b0, 1'b0};
  int            m     [2] = '{0, 0};
  logic [CW-1:0] mcmd  [2];
  logic [DW-1:0] mresp [2];
  logic [DW-1:0] dexp  [2];

  always @(posedge clk) begin
    for (int id = 0; id < 2; id++) begin
      if (rst_s[id]) begin
        act[id]  = 1'b0;
        m[id]    = 0;
        dexp[id] = '0;
      end else if (act[id]) begin
        m[id] = m[id] + 1;
        if (m[id] == half_of(id) * (2 * NB + 1)) dexp[id] = mresp[id];
        if (m[id] == half_of(id) * (2 * NB + 2)) act[id] = 1'b0;
      end else if (start_s[id]) begin
        act[id]   = 1'b1;
        m[id]     = 0;
        mcmd[id]  = cmd_s[id];
        mresp[id] = resp_s[id];
      end
    end
  end

  int cmp_h, cmp_fe, cmp_idx;
  bit cmp_inf, cmp_clk, cmp_sdi, cmp_val;

  always @(negedge clk) begin
    if (en) begin
      for (int id = 0; id < 2; id++) begin
        cmp_h   = half_of(id);
        cmp_fe  = cmp_h * (2 * NB + 1);
        cmp_inf = act[id] && (m[id] < cmp_fe);
        cmp_clk = cmp_inf && (m[id] >= cmp_h) && (((m[id] - cmp_h) % (2 * cmp_h)) < cmp_h);
        cmp_idx = m[id] / (2 * cmp_h);
        cmp_sdi = 1'b0;
        if (cmp_inf && cmp_idx < CW) cmp_sdi = mcmd[id][CW-1-cmp_idx];
        cmp_val = act[id] && (m[id] == cmp_fe);
        chk("busy",  id, 32'(busy_a[id]),  32'(act[id]));
        chk("csb",   id, 32'(csb_a[id]),   32'(!cmp_inf));
        chk("sclk",  id, 32'(sclk_a[id]),  32'(cmp_clk));
        chk("sdi",   id, 32'(sdi_a[id]),   32'(cmp_sdi));
        chk("valid", id, 32'(valid_a[id]), 32'(cmp_val));
        chk("data",  id, 32'(data_of(id)), 32'(dexp[id]));
      end
    end
  end

  // Per-frame measurements used by the literal checks.
  int            cyc = 0;
  int            busy_len [2] = '{0, 0};
  int            rises    [2] = '{0, 0};
  int            last_rise[2] = '{0, 0};
  int            sp_bad   [2] = '{0, 0};
  int            vcount   [2] = '{0, 0};
  int            csb_hi   [2] = '{0, 0};
  int            csb_gap  [2] = '{0, 0};
  int            idle_len [2] = '{0, 0};
  int            idle_bef [2] = '{0, 0};
  logic [NB-1:0] sdi_cap  [2];
  logic          bp [2] = '{1'b0, 1'b0};
  logic          cp [2] = '{1'b0, 1'b0};
  logic          sp [2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    if (en) begin
      cyc++;
      for (int id = 0; id < 2; id++) begin
        if (busy_a[id] && !bp[id]) begin
          idle_bef[id] = idle_len[id];
          busy_len[id] = 0;
          rises[id]    = 0;
          sp_bad[id]   = 0;
          sdi_cap[id]  = '0;
        end
        if (busy_a[id]) begin
          busy_len[id]++;
          idle_len[id] = 0;
        end else begin
          idle_len[id]++;
        end
        if (sclk_a[id] && !cp[id]) begin
          if (rises[id] > 0 && (cyc - last_rise[id]) != 2 * half_of(id)) sp_bad[id]++;
          last_rise[id] = cyc;
          rises[id]++;
          sdi_cap[id] = {sdi_cap[id][NB-2:0], sdi_a[id]};
        end
        if (!csb_a[id] && sp[id]) csb_gap[id] = csb_hi[id];
        csb_hi[id] = csb_a[id] ? csb_hi[id] + 1 : 0;
        if (valid_a[id]) vcount[id]++;
        bp[id] = busy_a[id];
        cp[id] = sclk_a[id];
        sp[id] = csb_a[id];
      end
    end
  end

  task automatic wait_busy(input int id, input logic val);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk); #1;
      if (busy_a[id] === val) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_busy[%0d]: got busy!=%0b, expected %0b within 1000 cycles", id, val, val);
    end
  endtask

  task automatic wait_len(input int id, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk); #1;
      if (busy_len[id] == n) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_len[%0d]: got busy_len=%0d, expected %0d", id, busy_len[id], n);
    end
  endtask

  task automatic run_txn(input int id, input logic [CW-1:0] c, input logic [DW-1:0] r,
                         input logic [NB-1:0] exp_sdi, input int exp_busy, input int poke);
    int v0;
    wait_busy(id, 1'b0);
    v0 = vcount[id];
    resp_s[id]  = r;
    cmd_s[id]   = c;
    start_s[id] = 1'b1;
    @(negedge clk); #1;
    start_s[id] = 1'b0;
    cmd_s[id]   = ~c;
    if (poke > 0) begin
      wait_len(id, poke);
      start_s[id] = 1'b1;
      cmd_s[id]   = 8'hFF;
      @(negedge clk); #1;
      start_s[id] = 1'b0;
    end
    wait_busy(id, 1'b0);
    chk("busy_len",     id, 32'(busy_len[id]),   32'(exp_busy));
    chk("sclk_rises",   id, 32'(rises[id]),      32'd24);
    chk("sdi_bits",     id, 32'(sdi_cap[id]),    32'(exp_sdi));
    chk("sclk_spacing", id, 32'(sp_bad[id]),     32'd0);
    chk("data_lit",     id, 32'(data_of(id)),    32'(r));
    chk("valid_pulses", id, 32'(vcount[id] - v0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within 50000 cycles");
    $fatal(1);
  end

  initial begin
    int v0;
    cmd_s  = '{8'h00, 8'h00};
    resp_s = '{16'h0000, 16'h0000};
    sdi_cap = '{'0, '0};
    rst_s  = 2'b11;
    repeat (3) @(negedge clk);
    en = 1'b1;
    for (int id = 0; id < 2; id++) begin
      chk("rst_busy",  id, 32'(busy_a[id]),   32'd0);
      chk("rst_csb",   id, 32'(csb_a[id]),    32'd1);
      chk("rst_sclk",  id, 32'(sclk_a[id]),   32'd0);
      chk("rst_sdi",   id, 32'(sdi_a[id]),    32'd0);
      chk("rst_valid", id, 32'(valid_a[id]),  32'd0);
      chk("rst_data",  id, 32'(data_of(id)),  32'd0);
    end
    #1;
    rst_s = 2'b00;
    repeat (2) @(negedge clk);
    #1;

    run_txn(0, 8'hA5, 16'h1234, 24'hA50000, 250, 0);
    run_txn(0, 8'h5A, 16'hAAAA, 24'h5A0000, 250, 0);
    run_txn(0, 8'h81, 16'h0001, 24'h810000, 250, 0);
    run_txn(0, 8'hC3, 16'hBEEF, 24'hC30000, 250, 40);

    // Abort mid-frame with reset.
    wait_busy(0, 1'b0);
    v0 = vcount[0];
    resp_s[0]  = 16'h1111;
    cmd_s[0]   = 8'h96;
    start_s[0] = 1'b1;
    @(negedge clk); #1;
    start_s[0] = 1'b0;
    wait_len(0, 100);
    rst_s[0] = 1'b1;
    @(negedge clk); #1;
    chk("abort_csb",   0, 32'(csb_a[0]),   32'd1);
    chk("abort_sclk",  0, 32'(sclk_a[0]),  32'd0);
    chk("abort_busy",  0, 32'(busy_a[0]),  32'd0);
    chk("abort_valid", 0, 32'(valid_a[0]), 32'd0);
    chk("abort_data",  0, 32'(data0),      32'd0);
    rst_s[0] = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("abort_no_pulse", 0, 32'(vcount[0] - v0), 32'd0);
    run_txn(0, 8'h3C, 16'h5A5A, 24'h3C0000, 250, 0);

    // Start held high: three back-to-back frames.
    wait_busy(0, 1'b0);
    v0 = vcount[0];
    resp_s[0]  = 16'hC001;
    cmd_s[0]   = 8'h69;
    start_s[0] = 1'b1;
    wait_busy(0, 1'b1);
    for (int f = 0; f < 2; f++) begin
      wait_busy(0, 1'b0);
      wait_busy(0, 1'b1);
      chk("held_idle_gap", 0, 32'(idle_bef[0]),     32'd1);
      chk("held_csb_gap5", 0, 32'(csb_gap[0] >= 5), 32'd1);
    end
    start_s[0] = 1'b0;
    wait_busy(0, 1'b0);
    chk("held_pulses", 0, 32'(vcount[0] - v0), 32'd3);
    chk("held_data",   0, 32'(data0),          32'h0000C001);
    chk("held_sdi",    0, 32'(sdi_cap[0]),     32'h00690000);

    run_txn(1, 8'hA5, 16'h1234, 24'hA50000, 50, 0);
    run_txn(1, 8'h0F, 16'h8001, 24'h0F0000, 50, 0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
